// File: rtl/sseg_scan_bcd_pkg.sv
// sseg_pkg: segment codes, digit decode and overflow-threshold helper for sseg_scan_bcd.
package sseg_pkg;

    typedef enum logic {IDLE, SHIFT} conv_state_t;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    function automatic logic [0:6] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

endpackage

// File: rtl/sseg_scan_bcd_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter, one shift per cycle, with overflow flag.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int BIN_W = 14,
    parameter int NDIG  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NDIG-1:0]    bcd,
    output logic                 ovf
);
    localparam int W  = 4 * NDIG + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [31:0] LIMIT = pow10(NDIG);

    conv_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d, adj, step;
    logic          ovf_q, ovf_d;

    always_comb begin
        adj = sh_q;
        for (int i = 0; i < NDIG; i++)
            if (adj[BIN_W+4*i +: 4] >= 4'd5) adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] + 4'd3;
        step    = adj << 1;
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sh_d    = W'(bin);
            ovf_d   = 32'(bin) >= LIMIT;
        end else if (state_q == SHIFT) begin
            sh_d    = step;
            cnt_d   = cnt_q + CW'(1);
            state_d = cnt_q == CW'(BIN_W - 1) ? IDLE : SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
        end
    end

    // bcd is the result of the step in flight, so it is final while done is high
    assign busy = state_q == SHIFT;
    assign done = busy && cnt_q == CW'(BIN_W - 1);
    assign bcd  = step[W-1 -: 4*NDIG];
    assign ovf  = ovf_q;

endmodule

// File: rtl/sseg_scan_bcd.sv
// sseg_scan_bcd: multiplexed seven-segment driver with binary-to-BCD conversion and blanking.
module sseg_scan_bcd
    import sseg_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int BIN_W    = 14,
    parameter int DIV      = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic [0:6]       sseg,
    output logic [NDIG-1:0]  an
);
    localparam int DW = $clog2(DIV);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    logic              done, ovf, lz, tc;
    logic [4*NDIG-1:0] bcd, disp_q, disp_d;
    logic              dovf_q, dovf_d;
    logic [DW-1:0]     div_q, div_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [0:6]        sseg_q, sseg_d;
    logic [NDIG-1:0]   an_q, an_d, blank;
    logic [3:0]        cur;

    bin2bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (value),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    // segments decode from the next display value so new digits appear the cycle busy drops
    always_comb begin
        disp_d = done ? bcd : disp_q;
        dovf_d = done ? ovf : dovf_q;
        tc     = div_q == DW'(DIV - 1);
        div_d  = tc ? '0 : div_q + DW'(1);
        idx_d  = !tc ? idx_q : idx_q == IW'(NDIG - 1) ? '0 : idx_q + IW'(1);
        lz     = 1'b1;
        blank  = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lz       = lz && disp_d[4*i +: 4] == 4'd0;
            blank[i] = lz && i != 0;
        end
        cur    = disp_d[4*idx_q +: 4];
        sseg_d = dovf_d ? SEG_DASH : (BLANK_LZ != 0 && blank[idx_q]) ? SEG_BLANK : seg_decode(cur);
        an_d   = ~(NDIG'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
            dovf_q <= 1'b0;
            div_q  <= '0;
            idx_q  <= '0;
            sseg_q <= SEG_BLANK;
            an_q   <= '1;
        end else begin
            disp_q <= disp_d;
            dovf_q <= dovf_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            sseg_q <= sseg_d;
            an_q   <= an_d;
        end
    end

    assign sseg = sseg_q;
    assign an   = an_q;

endmodule

// File: doc/sseg_scan_bcd.md
# sseg_scan_bcd

Parametrised multiplexed seven-segment display driver: accepts an unsigned binary value, converts it to BCD with a sequential double-dabble engine, and time-multiplexes NDIG digits onto a shared segment bus with per-digit anodes. It replaces the fixed two-number, four-digit BCD display block at the board-level output. Added over the previous generation: configurable digit count and input width, a load/busy handshake, leading-zero blanking and overflow indication.

## Interface
- NDIG, 4, number of digits driven (1..8)
- BIN_W, 14, input value width (1..27)
- DIV, 50000, clock cycles each digit stays lit (≥2)
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- value  in  BIN_W  binary number to display
- load  in  1  capture `value` when not busy
- busy  out  1  conversion in progress
- sseg  out  [0:6]  segments a..g, active-low
- an  out  NDIG  digit anodes, one-hot active-low; an[0] = least significant digit

## Operation
- Reset: sseg=1111111, an=all ones, busy=0, display digits=0, overflow=0, scan index=0, divider=0.
- Load accepted only when load=1 and busy=0; load while busy is ignored (no queueing).
- On accept: capture value, flag overflow if value ≥ 10^NDIG, start double-dabble: BIN_W iterations, one per cycle, each doing add-3 on every nibble ≥5, then shifting left by 1 bit.
- On completion: all NDIG display digits update atomically in one cycle. If overflow, every digit shows a dash (1111110).
- Scan: the divider counts 0..DIV-1. At the terminal count, the scan index advances, wrapping from NDIG-1 to 0. an drives the current index low. sseg shows the decode of the current digit.
- Decode (a..g, active-low): 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, blank 1111111.
- Leading-zero blanking (BLANK_LZ=1): digit i is blank if it and all higher digits are 0. Digit 0 is never blanked. Does not apply under overflow.
- Reset mid-conversion: conversion aborts, and the reset values above apply on the next cycle.

## Timing
- Load accepted at cycle k → busy=1 in cycles k+1..k+BIN_W. New digits are visible on sseg from cycle k+BIN_W+1, when busy=0 again. A new load is accepted in cycle k+BIN_W+1.
- sseg and an are registered; they change together, one cycle after the index changes. There is never a cycle with two anodes active.
- First cycle after rst deasserts: an[0]=0, sseg=0000001 ("0").
- Each digit is lit for exactly DIV cycles. A full frame is NDIG·DIV cycles.
- Conversion does not disturb the scan phase.

## Structure
- Package sseg_pkg holds:
  - segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - function seg_decode(logic [3:0]) returning [0:6];
  - function pow10(n) for the overflow threshold.
- Sub-module bin2bcd_seq (params BIN_W, NDIG; ports clk, rst, start, bin, busy, done, bcd[4·NDIG-1:0], ovf) contains the double-dabble FSM with states IDLE → SHIFT (BIN_W cycles) → IDLE, pulsing done in the last SHIFT cycle.
- Top level contains the display register, divider, scan index, blanking logic and output registers.

## Test plan
Bench uses DIV=4, NDIG=4, BIN_W=14.

- Reset then idle: an cycles 1110→1101→1011→0111, 4 cycles each. Digit 0 shows 0000001, digits 1–3 show 1111111.
- Load 5: busy high for 14 cycles, then digit 0 shows 0100100 and the others are blank. With BLANK_LZ=0, digits 1–3 show 0000001.
- Load 9999 → digits 9,9,9,9. Load 1024 → 4,2,0,1; the interior zero is shown, not blanked.
- Load 10000 (overflow) → all four digits show 1111110.
- Load 15, then assert load=1 with value 7 during busy → 7 is ignored and the display shows 1,5. A load of 7 at cycle k+15 is accepted.
- Assert rst in the 5th conversion cycle → busy=0, display 0, an=1111 during reset. The scan restarts at digit 0 after reset releases.
